// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and types for the SHA-256 message-schedule block.
//   WORD_W / BLOCK_W : schedule word and padded block widths
//   S0_* / S1_*      : rotate and shift amounts of the small sigma functions
//   state_e          : schedule expander FSM states
package sha256_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned WIN_N   = BLOCK_W / WORD_W;

    localparam int unsigned S0_R1 = 7;
    localparam int unsigned S0_R2 = 18;
    localparam int unsigned S0_SH = 3;
    localparam int unsigned S1_R1 = 17;
    localparam int unsigned S1_R2 = 19;
    localparam int unsigned S1_SH = 10;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/sha256_rotr.sv
// sha256_rotr: parameterised constant rotate-right.
//   x_i : input word
//   y_o : x_i rotated right by AMT bits (AMT must be 1..WIDTH-1)
module sha256_rotr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT   = 1
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = {x_i[AMT-1:0], x_i[WIDTH-1:AMT]};

endmodule

// File: rtl/sha256_small_sigma.sv
// sha256_small_sigma: SHA-256 small sigma, purely combinational.
//   SEL = 0 : sigma0(x) = rotr7  ^ rotr18 ^ shr3
//   SEL = 1 : sigma1(x) = rotr17 ^ rotr19 ^ shr10
//   x_i : input word
//   y_o : sigma result
module sha256_small_sigma
    import sha256_pkg::*;
#(
    parameter int unsigned SEL = 0
) (
    input  logic [WORD_W-1:0] x_i,
    output logic [WORD_W-1:0] y_o
);

    localparam int unsigned R1 = (SEL == 0) ? S0_R1 : S1_R1;
    localparam int unsigned R2 = (SEL == 0) ? S0_R2 : S1_R2;
    localparam int unsigned SH = (SEL == 0) ? S0_SH : S1_SH;

    logic [WORD_W-1:0] rot_a;
    logic [WORD_W-1:0] rot_b;

    sha256_rotr #(
        .WIDTH (WORD_W),
        .AMT   (R1)
    ) u_rot_a (
        .x_i (x_i),
        .y_o (rot_a)
    );

    sha256_rotr #(
        .WIDTH (WORD_W),
        .AMT   (R2)
    ) u_rot_b (
        .x_i (x_i),
        .y_o (rot_b)
    );

    assign y_o = rot_a ^ rot_b ^ (x_i >> SH);

endmodule

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 message-schedule expander.
// Accepts one padded 512-bit block and streams W[0..ROUNDS-1], one word per handshake.
// A 16-word sliding window holds W[t..t+15]; every accepted word shifts it down by one
// and appends the next expanded word.
//   clk, rst_n           : clock, asynchronous active-low reset
//   blk_valid/blk_ready  : upstream block handshake (blk_data sampled on acceptance)
//   blk_data             : padded block, word 0 in blk_data[511:480]
//   w_valid/w_ready      : downstream word handshake
//   w_data, w_idx        : current word W[t] and its index t
//   busy                 : high while a block is being streamed
// Optional build macro SHA256_MSG_SCHED_PERF_EN adds:
//   blk_cnt   : completed blocks, wraps
//   stall_cnt : RUN cycles with w_ready low, saturates
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [BLOCK_W-1:0] blk_data,
    output logic               w_valid,
    input  logic               w_ready,
    output logic [WORD_W-1:0]  w_data,
    output logic [5:0]         w_idx,
    output logic               busy
`ifdef SHA256_MSG_SCHED_PERF_EN
    ,
    output logic [31:0]        blk_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] win_q [WIN_N];
    logic [WORD_W-1:0] win_d [WIN_N];
    logic [5:0]        idx_q, idx_d;

    logic [WORD_W-1:0] sig0;
    logic [WORD_W-1:0] sig1;
    logic [WORD_W-1:0] next_word;
    logic              w_hs;
    logic              last_hs;

    sha256_small_sigma #(
        .SEL (0)
    ) u_sigma0 (
        .x_i (win_q[1]),
        .y_o (sig0)
    );

    sha256_small_sigma #(
        .SEL (1)
    ) u_sigma1 (
        .x_i (win_q[14]),
        .y_o (sig1)
    );

    // W[t+16] from the window holding W[t..t+15]; sum wraps mod 2^32.
    assign next_word = sig1 + win_q[9] + sig0 + win_q[0];

    assign w_hs    = (state_q == RUN) && w_ready;
    assign last_hs = w_hs && (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    for (int unsigned k = 0; k < WIN_N; k++) begin
                        win_d[k] = blk_data[BLOCK_W-1-WORD_W*k -: WORD_W];
                    end
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_ready) begin
                    for (int unsigned k = 0; k < WIN_N - 1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[WIN_N-1] = next_word;
                    if (last_hs) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int unsigned k = 0; k < WIN_N; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
        end
    end

    // All outputs come straight from flops: no path from w_ready or blk_valid.
    assign blk_ready = (state_q == IDLE);
    assign w_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign w_data    = win_q[0];
    assign w_idx     = idx_q;

`ifdef SHA256_MSG_SCHED_PERF_EN
    logic [31:0] blk_cnt_q, blk_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        blk_cnt_d   = blk_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (last_hs) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
        if ((state_q == RUN) && !w_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign blk_cnt   = blk_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
`timescale 1ns/1ps
module tb_sha256_msg_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         blk_valid, blk_ready, w_valid, w_ready, busy;
    logic [511:0] blk_data;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;

    logic         v16, rdy16, wv16, r16, busy16;
    logic [511:0] d16;
    logic [31:0]  wd16;
    logic [5:0]   wi16;

`ifdef SHA256_MSG_SCHED_PERF_EN
    logic [31:0] blk_cnt, stall_cnt, blk_cnt16, stall_cnt16;
`endif

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .busy      (busy)
`ifdef SHA256_MSG_SCHED_PERF_EN
        ,
        .blk_cnt   (blk_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    sha256_msg_sched #(.ROUNDS(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (v16),
        .blk_ready (rdy16),
        .blk_data  (d16),
        .w_valid   (wv16),
        .w_ready   (r16),
        .w_data    (wd16),
        .w_idx     (wi16),
        .busy      (busy16)
`ifdef SHA256_MSG_SCHED_PERF_EN
        ,
        .blk_cnt   (blk_cnt16),
        .stall_cnt (stall_cnt16)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_blk   = 0;
    logic [31:0] exp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: straight from the SHA-256 schedule definition.
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic model(input logic [511:0] b, output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
        for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
    endtask

    function automatic logic rdy_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge the first word is due.
    task automatic start_block(input logic [511:0] b);
        blk_valid = 1'b1;
        blk_data  = b;
        chk("blk_ready_idle", 32'(blk_ready), 32'd1);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("first_word_latency", 32'(w_valid), 32'd1);
    endtask

    // Drains one block from RUN, checking every word, index and stall stability.
    task automatic drain(input logic [31:0] exp [64], input int mode, output logic [31:0] got [64]);
        int n = 0;
        int c = 0;
        logic prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        while (n < 64 && c < 1000) begin
            if (prev_stall) begin
                chk("stall_data_stable", w_data, pd);
                chk("stall_idx_stable", 32'(w_idx), 32'(pi));
            end
            chk("w_valid_run", 32'(w_valid), 32'd1);
            chk("busy_run", 32'(busy), 32'd1);
            chk("blk_ready_run", 32'(blk_ready), 32'd0);
            if (!w_valid) break;
            w_ready = rdy_for(mode, c);
            if (w_ready) begin
                chk("w_idx", 32'(w_idx), 32'(n));
                chk("w_data", w_data, exp[n]);
                got[n] = w_data;
                n++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                pd = w_data;
                pi = w_idx;
                exp_stall++;
            end
            c++;
            @(negedge clk);
        end
        w_ready = 1'b1;
        chk("words_emitted", 32'(n), 32'd64);
        if (mode == 0) chk("consecutive_cycles", 32'(c), 32'd64);
        chk("w_valid_after_last", 32'(w_valid), 32'd0);
        chk("blk_ready_after_last", 32'(blk_ready), 32'd1);
        chk("w_idx_after_last", 32'(w_idx), 32'd0);
        exp_blk++;
    endtask

    typedef struct {
        logic [511:0] blk;
        int           mode;
        int           idx;
        logic [31:0]  exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] abc, ones, rb;
        logic [31:0]  ea [64];
        logic [31:0]  eb [64];
        logic [31:0]  got [64];
        vec_t         vecs [8];
        int           n;

        abc  = {32'h6162_6380, 448'h0, 32'h0000_0018};
        ones = '1;

        vecs[0] = '{abc,  0, 0,  32'h6162_6380};
        vecs[1] = '{abc,  0, 15, 32'h0000_0018};
        vecs[2] = '{abc,  0, 16, 32'h6162_6380};
        vecs[3] = '{abc,  0, 17, 32'h000F_0000};
        vecs[4] = '{abc,  1, 18, 32'h7DA8_6405};
        vecs[5] = '{abc,  1, 19, 32'h6000_03C6};
        vecs[6] = '{ones, 0, 16, 32'h203F_FFFC};
        vecs[7] = '{ones, 2, 0,  32'hFFFF_FFFF};

        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b1;
        v16 = 1'b0; d16 = '0; r16 = 1'b1;
        #12;
        chk("rst_blk_ready", 32'(blk_ready), 32'd1);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_w_idx", 32'(w_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors: golden words plus full model comparison per block.
        for (int i = 0; i < 8; i++) begin
            model(vecs[i].blk, ea);
            start_block(vecs[i].blk);
            drain(ea, vecs[i].mode, got);
            chk($sformatf("vec%0d_W%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
        end

        // Random blocks with random backpressure.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) rb[511-32*k -: 32] = $urandom;
            model(rb, ea);
            start_block(rb);
            drain(ea, 2, got);
        end

        // blk_valid held through RUN: second block only taken after W63.
        for (int k = 0; k < 16; k++) rb[511-32*k -: 32] = $urandom;
        model(abc, ea);
        model(rb, eb);
        blk_valid = 1'b1;
        blk_data  = abc;
        @(negedge clk);
        blk_data = rb;
        drain(ea, 0, got);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("b2_w_valid", 32'(w_valid), 32'd1);
        chk("b2_w_idx", 32'(w_idx), 32'd0);
        chk("b2_W0", w_data, eb[0]);
        drain(eb, 0, got);

        // Asynchronous reset in the middle of a block.
        start_block(abc);
        n = 0;
        while (w_idx != 6'd30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_idx30", 32'(w_idx), 32'd30);
        rst_n = 1'b0;
        #1;
        chk("midrst_w_valid", 32'(w_valid), 32'd0);
        chk("midrst_blk_ready", 32'(blk_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_w_idx", 32'(w_idx), 32'd0);
        chk("midrst_w_data", w_data, 32'd0);
        exp_blk   = 0;
        exp_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_block(abc);
        chk("postrst_W0", w_data, 32'h6162_6380);
        drain(ea, 1, got);

        // ROUNDS=16 instance: pass-through words only, then idle.
        for (int k = 0; k < 16; k++) rb[511-32*k -: 32] = $urandom;
        v16 = 1'b1;
        d16 = rb;
        chk("r16_blk_ready", 32'(rdy16), 32'd1);
        @(negedge clk);
        v16 = 1'b0;
        n = 0;
        while (n < 16) begin
            chk("r16_w_valid", 32'(wv16), 32'd1);
            if (!wv16) break;
            chk("r16_w_idx", 32'(wi16), 32'(n));
            chk("r16_w_data", wd16, rb[511-32*n -: 32]);
            n++;
            @(negedge clk);
        end
        chk("r16_w_valid_after", 32'(wv16), 32'd0);
        chk("r16_blk_ready_after", 32'(rdy16), 32'd1);

`ifdef SHA256_MSG_SCHED_PERF_EN
        chk("blk_cnt", blk_cnt, exp_blk);
        chk("stall_cnt", stall_cnt, exp_stall);
        chk("blk_cnt16", blk_cnt16, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
